// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared envelope state encodings and Q2 format helpers
package synth_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int Q2_INT_BITS = 2;

  // Left shift that places a level word just below the Q2 integer bits.
  function automatic int q2_shift(input int env_bits, input int lvl_bits);
    return env_bits - Q2_INT_BITS - lvl_bits;
  endfunction

endpackage

// File: rtl/env_step.sv
// rtl/env_step.sv - one-pole RC step toward a target with saturation to [0, max positive]
module env_step #(
  parameter int ENV_BITS = 24,
  parameter int TAU_BITS = 16
) (
  input  logic [ENV_BITS-1:0] env,
  input  logic [ENV_BITS-1:0] target,
  input  logic [TAU_BITS-1:0] tau,
  output logic [ENV_BITS-1:0] nxt
);

  localparam logic signed [ENV_BITS+1:0] ACC_MAX = $signed({3'b000, {(ENV_BITS-1){1'b1}}});

  logic signed [ENV_BITS:0]   sum;
  logic signed [ENV_BITS:0]   prod;
  logic signed [ENV_BITS+1:0] acc;

  assign sum = $signed({1'b0, target}) - $signed({1'b0, env});

  fixed_point_mult #(
    .AW(ENV_BITS + 1),
    .BW(TAU_BITS)
  ) u_mult (
    .a(sum),
    .b(tau),
    .p(prod)
  );

  assign acc = $signed({2'b00, env}) + $signed({prod[ENV_BITS], prod});

  always_comb begin
    nxt = acc[ENV_BITS-1:0];
    if (acc < 0) begin
      nxt = '0;
    end else if (acc > ACC_MAX) begin
      nxt = {1'b0, {(ENV_BITS-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fixed_point_mult.sv
// rtl/fixed_point_mult.sv - signed value times unsigned pure-fraction coefficient, floor rounded
module fixed_point_mult #(
  parameter int AW = 25,
  parameter int BW = 16
) (
  input  logic signed [AW-1:0] a,
  input  logic        [BW-1:0] b,
  output logic signed [AW-1:0] p
);

  logic signed [AW+BW:0] full;
  logic                  unused_bits;

  assign full = a * $signed({1'b0, b});
  // b < 1.0, so the scaled product always fits back in AW bits; dropping the low bits floors.
  assign p           = full[BW +: AW];
  assign unused_bits = ^{full[AW+BW], full[BW-1:0]};

endmodule

// File: rtl/adsr_env_mux.sv
// rtl/adsr_env_mux.sv - N-voice ADSR envelope generator on one time-multiplexed RC datapath
module adsr_env_mux
  import synth_pkg::*;
#(
  parameter int N_VOICES = 8,
  parameter int ENV_BITS = 24,
  parameter int TAU_BITS = 16,
  parameter int VEL_BITS = 16,
  parameter int MIN_ENV  = 8,
  parameter int SETTLE   = 64,
  localparam int VW = $clog2(N_VOICES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [N_VOICES-1:0]          gate,
  input  logic [N_VOICES*VEL_BITS-1:0] velocity,
  input  logic [VEL_BITS-1:0]          sustain_level,
  input  logic [TAU_BITS-1:0]          attack_tau,
  input  logic [TAU_BITS-1:0]          decay_tau,
  input  logic [TAU_BITS-1:0]          release_tau,
  output logic [ENV_BITS-1:0]          env_out,
  output logic                         env_valid,
  output logic [VW-1:0]                env_voice,
  output logic [N_VOICES-1:0]          voice_free,
  output logic                         busy,
  output logic                         overrun
);

  localparam int SHIFT = q2_shift(ENV_BITS, VEL_BITS);
  localparam logic signed [ENV_BITS:0] SETTLE_S = (ENV_BITS + 1)'(SETTLE);

  logic [VW-1:0]       cnt;
  logic [2:0]          st_r   [N_VOICES];
  logic [ENV_BITS-1:0] env_r  [N_VOICES];
  logic [ENV_BITS-1:0] peak_r [N_VOICES];

  logic [2:0]            st_c, st_n;
  logic [ENV_BITS-1:0]   env_c, peak_c, env_n, peak_n, tgt, nxt, peak_in, sus_env;
  logic [TAU_BITS-1:0]   tau;
  logic [VEL_BITS-1:0]   vel_c;
  logic                  g_c, free_n;
  logic signed [ENV_BITS:0] nxt_s, peak_s, dsus;

  assign st_c    = st_r[cnt];
  assign env_c   = env_r[cnt];
  assign peak_c  = peak_r[cnt];
  assign g_c     = gate[cnt];
  assign vel_c   = velocity[cnt*VEL_BITS +: VEL_BITS];
  assign peak_in = ENV_BITS'(vel_c) << SHIFT;
  assign sus_env = ENV_BITS'(sustain_level) << SHIFT;
  assign nxt_s   = $signed({1'b0, nxt});
  assign peak_s  = $signed({1'b0, peak_c});
  assign dsus    = nxt_s - $signed({1'b0, sus_env});

  always_comb begin
    tgt = env_c;
    tau = '0;
    case (st_c)
      ST_ATTACK:  begin tgt = peak_c;  tau = attack_tau;  end
      ST_DECAY:   begin tgt = sus_env; tau = decay_tau;   end
      ST_RELEASE: begin tgt = '0;      tau = release_tau; end
      default:    ;
    endcase
  end

  env_step #(
    .ENV_BITS(ENV_BITS),
    .TAU_BITS(TAU_BITS)
  ) u_step (
    .env(env_c),
    .target(tgt),
    .tau(tau),
    .nxt(nxt)
  );

  always_comb begin
    st_n   = st_c;
    env_n  = nxt;
    peak_n = peak_c;
    free_n = 1'b0;
    case (st_c)
      ST_IDLE: begin
        env_n = env_c;
        if (g_c) begin
          st_n   = ST_ATTACK;
          peak_n = peak_in;
        end
      end
      ST_ATTACK: begin
        if (!g_c) st_n = ST_RELEASE;
        else if (nxt_s >= peak_s - SETTLE_S) st_n = ST_DECAY;
      end
      ST_DECAY: begin
        if (!g_c) begin
          st_n = ST_RELEASE;
        end else if (dsus <= SETTLE_S && dsus >= -SETTLE_S) begin
          st_n  = ST_SUSTAIN;
          env_n = sus_env;
        end
      end
      ST_SUSTAIN: begin
        env_n = sus_env;
        if (!g_c) st_n = ST_RELEASE;
      end
      // A retrigger outranks the floor test, so no voice_free when both occur.
      ST_RELEASE: begin
        if (g_c) begin
          st_n   = ST_ATTACK;
          peak_n = peak_in;
        end else if (nxt < ENV_BITS'(MIN_ENV)) begin
          st_n   = ST_IDLE;
          env_n  = '0;
          free_n = 1'b1;
        end
      end
      default: begin
        st_n  = ST_IDLE;
        env_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      cnt        <= '0;
      overrun    <= 1'b0;
      env_valid  <= 1'b0;
      env_voice  <= '0;
      env_out    <= '0;
      voice_free <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        st_r[i]   <= ST_IDLE;
        env_r[i]  <= '0;
        peak_r[i] <= '0;
      end
    end else begin
      voice_free <= '0;
      env_valid  <= busy;
      if (tick) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          busy <= 1'b1;
          cnt  <= '0;
        end
      end
      if (busy) begin
        st_r[cnt]       <= st_n;
        env_r[cnt]      <= env_n;
        peak_r[cnt]     <= peak_n;
        env_out         <= env_n;
        env_voice       <= cnt;
        voice_free[cnt] <= free_n;
        if (cnt == VW'(N_VOICES - 1)) busy <= 1'b0;
        else cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adsr_env_mux.sv
// tb/tb_adsr_env_mux.sv - directed self-checking bench for adsr_env_mux
module tb_adsr_env_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [7:0]   gate;
  logic [127:0] velocity;
  logic [15:0]  sustain_level, attack_tau, decay_tau, release_tau;
  logic [23:0]  env_out;
  logic         env_valid;
  logic [2:0]   env_voice;
  logic [7:0]   voice_free;
  logic         busy, overrun;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int free3  = 0;
  int free5  = 0;

  logic [23:0] cap_env [8];
  logic [7:0]  cap_free;
  int          nvalid, nbusy;
  logic        order_ok;
  int          m, mn;

  adsr_env_mux dut (
    .clk(clk), .rst(rst), .tick(tick), .gate(gate), .velocity(velocity),
    .sustain_level(sustain_level), .attack_tau(attack_tau), .decay_tau(decay_tau),
    .release_tau(release_tau), .env_out(env_out), .env_valid(env_valid),
    .env_voice(env_voice), .voice_free(voice_free), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (voice_free[3]) free3++;
    if (voice_free[5]) free5++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sweep();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    nvalid = 0; nbusy = 0; cap_free = '0; order_ok = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (busy) nbusy++;
      if (env_valid) begin
        if (env_voice != 3'(nvalid)) order_ok = 1'b0;
        cap_env[env_voice] = env_out;
        nvalid++;
      end
      cap_free |= voice_free;
      @(negedge clk);
    end
  endtask

  task automatic set_vel(input int v, input logic [15:0] val);
    velocity[v*16 +: 16] = val;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; gate = '0; velocity = '0;
    sustain_level = 16'h2000; attack_tau = 16'h8000; decay_tau = 16'hFFFF; release_tau = 16'h4000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state and idle sweep
    chk("rst_env_valid", 32'(env_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_env_out", 32'(env_out), 0);
    chk("rst_voice_free", 32'(voice_free), 0);
    sweep();
    chk("idle_nvalid", 32'(nvalid), 8);
    chk("idle_order", 32'(order_ok), 1);
    chk("idle_busy_cycles", 32'(nbusy), 8);
    for (int v = 0; v < 8; v++) chk($sformatf("idle_env_v%0d", v), 32'(cap_env[v]), 0);

    // 2: attack on voice 3 halves the gap, then decay, then sustain
    set_vel(3, 16'h3C00);
    gate[3] = 1'b1;
    sweep();
    chk("attack_entry_env", 32'(cap_env[3]), 0);
    for (int k = 1; k <= 14; k++) begin
      sweep();
      chk($sformatf("attack_k%0d", k), 32'(cap_env[3]), 983040 - (983040 >> k));
    end
    sweep();
    chk("decay_to_sustain", 32'(cap_env[3]), 524288);
    chk("other_voice_idle", 32'(cap_env[2]), 0);
    sweep();
    chk("sustain_hold", 32'(cap_env[3]), 524288);
    sustain_level = 16'h2100;
    sweep();
    chk("sustain_tracks", 32'(cap_env[3]), 540672);

    // 3: release to floor, single voice_free pulse
    gate[3] = 1'b0;
    sweep();
    chk("release_entry", 32'(cap_env[3]), 540672);
    m = 540672;
    for (int s = 0; s < 60; s++) begin
      mn = m - ((m + 3) >> 2);
      sweep();
      if (mn < 8) begin
        chk("release_floor_env", 32'(cap_env[3]), 0);
        chk("release_floor_free", 32'(cap_free[3]), 1);
        break;
      end
      chk($sformatf("release_s%0d", s), 32'(cap_env[3]), 32'(mn));
      m = mn;
    end
    sweep();
    chk("idle_after_release", 32'(cap_env[3]), 0);
    chk("free3_once", 32'(free3), 1);

    // 4: retrigger on voice 5, then same-cycle floor and gate
    sustain_level = 16'h2000;
    set_vel(5, 16'h3C00);
    gate[5] = 1'b1;
    sweep(); chk("v5_attack_entry", 32'(cap_env[5]), 0);
    sweep(); chk("v5_attack_1", 32'(cap_env[5]), 491520);
    sweep(); chk("v5_attack_2", 32'(cap_env[5]), 737280);
    gate[5] = 1'b0;
    sweep(); chk("v5_to_release", 32'(cap_env[5]), 860160);
    sweep(); chk("v5_release_1", 32'(cap_env[5]), 645120);
    gate[5] = 1'b1;
    set_vel(5, 16'h2000);
    sweep(); chk("v5_retrigger_cont", 32'(cap_env[5]), 483840);
    sweep(); chk("v5_reattack", 32'(cap_env[5]), 504064);
    gate[5] = 1'b0;
    sweep(); chk("v5_to_release2", 32'(cap_env[5]), 514176);
    release_tau = 16'hFFFF;
    gate[5] = 1'b1;
    sweep();
    chk("v5_gate_beats_floor", 32'(cap_env[5]), 7);
    chk("v5_no_free", 32'(free5), 0);
    sweep(); chk("v5_attack_from_7", 32'(cap_env[5]), 262147);
    gate[5] = 1'b0;
    sweep(); chk("v5_to_release3", 32'(cap_env[5]), 393217);
    sweep();
    chk("v5_floor_env", 32'(cap_env[5]), 0);
    chk("v5_floor_free", 32'(free5), 1);

    // 5: ticks every 4 cycles
    chk("overrun_clear", 32'(overrun), 0);
    nvalid = 0; nbusy = 0;
    for (int c = 0; c < 24; c++) begin
      tick = (c < 16 && c % 4 == 0);
      if (env_valid) nvalid++;
      if (busy) nbusy++;
      @(negedge clk);
    end
    tick = 1'b0;
    chk("overrun_valids", 32'(nvalid), 16);
    chk("overrun_busy_cycles", 32'(nbusy), 16);
    chk("overrun_set", 32'(overrun), 1);
    repeat (5) @(negedge clk);
    chk("overrun_sticky", 32'(overrun), 1);

    // 6: reset mid-sweep
    release_tau = 16'h4000;
    set_vel(3, 16'h3C00);
    gate[3] = 1'b1;
    sweep();
    sweep();
    chk("pre_rst_v3", 32'(cap_env[3]), 491520);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_env_valid", 32'(env_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_quiet", 32'(env_valid), 0);
    sweep();
    chk("post_rst_nvalid", 32'(nvalid), 8);
    chk("post_rst_order", 32'(order_ok), 1);
    for (int v = 0; v < 8; v++) chk($sformatf("post_rst_env_v%0d", v), 32'(cap_env[v]), 0);
    sweep();
    chk("post_rst_v3_attack", 32'(cap_env[3]), 491520);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
